req_ack_responder: RTL

- Responder end of the single-bit req/ack level handshake; answers an initiator's req with a registered ack after a programmable delay.
- Holds ack high while req stays high (four-phase), so a correct initiator always satisfies "req implies ack" once the delay has elapsed.
- Returns a response word derived from the request data and counts completed transactions.
- Sits beside protocol-checking assertion benches as the DUT-side counterpart to the req driver.

---
 rtl/req_ack_responder.sv | 73 +++++++
 1 files changed

// File: rtl/req_ack_responder.sv
// req_ack_responder: four-phase req/ack responder with programmable ack delay, response word and transaction count
module req_ack_responder #(
  parameter int DATA_W    = 8,
  parameter int ACK_DELAY = 2,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [DATA_W-1:0] req_data,
  output logic              ack,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              err,
  output logic [CNT_W-1:0]  txn_cnt
);
  localparam int CW = ACK_DELAY > 1 ? $clog2(ACK_DELAY) : 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_REL} state_t;
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] d;
  // handshake FSM; every output is registered and err defaults low so it only pulses after a WAIT abort
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      d        <= '0;
      ack      <= 1'b0;
      rsp_data <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
      txn_cnt  <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: if (req) begin
          d    <= req_data;
          busy <= 1'b1;
          if (ACK_DELAY == 0) begin
            state    <= S_ACK;
            ack      <= 1'b1;
            rsp_data <= req_data + 1'b1;
          end else begin
            state <= S_WAIT;
            cnt   <= CW'(ACK_DELAY - 1);
          end
        end
        S_WAIT: if (!req) begin
          err   <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end else if (cnt == '0) begin
          state    <= S_ACK;
          ack      <= 1'b1;
          rsp_data <= d + 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
        S_ACK: if (!req) begin
          ack     <= 1'b0;
          busy    <= 1'b0;
          txn_cnt <= txn_cnt + 1'b1;
          state   <= S_REL;
        end
        S_REL: begin
          rsp_data <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
